fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 20, instruction address width.
REQ-002 Parameter INSTR_W, 32, instruction width.
REQ-003 Parameter RESET_INSTR, 32'h00000033, value held on instr_fetch after reset (NOP).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; ports SHALL be named as below.
REQ-005 CLK  in  1  clock; all state SHALL change on its rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 fetch_enable  in  1  request to fetch the instruction at fetch_addr.
REQ-008 fetch_addr  in  ADDR_W  fetch address (controller nextPC).
REQ-009 new_instr  in  1  controller has consumed instr_fetch.
REQ-010 fetch_valid  out  1  instr_fetch holds a valid instruction.
REQ-011 instr_fetch  out  INSTR_W  fetched instruction.
REQ-012 mem_req  out  1  read request to instruction memory/icache.
REQ-013 mem_addr  out  ADDR_W  request address.
REQ-014 mem_ready  in  1  memory accepts the request this cycle.
REQ-015 mem_rvalid  in  1  read data valid.
REQ-016 mem_rdata  in  INSTR_W  read data.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, VALID.
REQ-018 IDLE: fetch_enable=1 -> latch fetch_addr into mem_addr, go REQ.
REQ-019 REQ: mem_req=1 and mem_addr stable until mem_ready=1, then go WAIT.
REQ-020 WAIT: mem_rvalid=1 -> register mem_rdata into instr_fetch, set fetch_valid, go VALID.
REQ-021 mem_rvalid is accepted only in WAIT and only in a cycle after mem_ready was sampled; elsewhere it SHALL be ignored.
REQ-022 VALID: instr_fetch and fetch_valid held stable until new_instr=1.
REQ-023 VALID with new_instr=1: fetch_valid cleared next cycle; if fetch_enable=1 in the same cycle, latch fetch_addr and go REQ, else go IDLE.
REQ-024 Minimum latency: fetch_enable at cycle N (IDLE) -> mem_req at N+1 -> with mem_ready at N+1 and mem_rvalid at N+2, fetch_valid=1 at N+3.
REQ-025 Redirect: fetch_enable=1 in REQ or WAIT with fetch_addr != mem_addr SHALL set a discard flag and latch the new address; the outstanding response is dropped (fetch_valid stays 0) and the FSM goes REQ with the new address.
REQ-026 fetch_enable in REQ/WAIT with the same address SHALL be ignored.
REQ-027 Only one memory request SHALL be outstanding at any time.
REQ-028 mem_addr + 4 wraps modulo 2^ADDR_W.

Reset
REQ-029 Reset SHALL force state IDLE, fetch_valid=0, instr_fetch=RESET_INSTR, mem_req=0, mem_addr=0, discard flag=0, prefetch buffer invalid.
REQ-030 Reset mid-transaction SHALL abandon the request; responses arriving in IDLE SHALL be ignored.

Configuration
REQ-031 Macro FETCH_PREFETCH_EN: when defined, in VALID with no request outstanding the block SHALL issue a request for held address + 4 into a one-entry prefetch buffer (data, address, valid).
REQ-032 With FETCH_PREFETCH_EN, fetch_enable whose fetch_addr equals a valid prefetch address SHALL set fetch_valid on the next cycle without a memory request; a mismatch invalidates the buffer and discards any in-flight prefetch response.
REQ-033 Without FETCH_PREFETCH_EN, no request SHALL be issued in VALID and behaviour is exactly REQ-017..REQ-030.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enum, ADDR_W/INSTR_W defaults and the NOP constant.
REQ-035 The prefetch buffer SHALL be a sub-module fetch_prefetch_buf, instantiated only under FETCH_PREFETCH_EN.

Verification
REQ-036 Reset release, fetch_enable with fetch_addr 0x00000, mem_ready at once, mem_rdata 0x00500093 next cycle -> fetch_valid=1 with instr_fetch 0x00500093 three cycles after enable.
REQ-037 mem_ready held low 4 cycles -> mem_req and mem_addr stable all 4 cycles; exactly one acceptance.
REQ-038 In WAIT, fetch_enable with 0x00040 (pending 0x00010) -> old data dropped, new request to 0x00040, fetch_valid only with the 0x00040 data.
REQ-039 VALID with new_instr and fetch_enable in the same cycle at 0x00014 -> fetch_valid low one cycle, mem_req to 0x00014 next cycle.
REQ-040 Reset asserted in WAIT, mem_rvalid after release -> fetch_valid stays 0, instr_fetch=0x00000033.
REQ-041 FETCH_PREFETCH_EN: holding 0xFFFFC -> prefetch request to 0x00000; fetch_enable at 0x00000 -> fetch_valid next cycle, no mem_req.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// Contents: the FSM state enum, default address/instruction widths and the
// NOP encoding held on instr_fetch out of reset.
package fetch_pkg;

  localparam int          ADDR_W_DEF  = 20;
  localparam int          INSTR_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0033;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer (address, data, valid) for the fetch unit.
// Latency: a fill is visible to lookup one cycle after fill_vld; lookup is combinational.
// Backpressure: none; invalidate has priority over a fill in the same cycle.
//
// Ports: CLK, reset (async active-high); fill_vld/fill_addr/fill_dat load the
// entry; inval clears it; lookup_addr is compared against the stored address
// and hit reports a valid match; buf_vld/buf_dat expose the entry.
module fetch_prefetch_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               fill_vld,
  input  logic [ADDR_W-1:0]  fill_addr,
  input  logic [INSTR_W-1:0] fill_dat,
  input  logic               inval,
  input  logic [ADDR_W-1:0]  lookup_addr,
  output logic               buf_vld,
  output logic [INSTR_W-1:0] buf_dat,
  output logic               hit
);

  logic [ADDR_W-1:0] buf_addr;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_dat  <= '0;
    end else if (inval) begin
      buf_vld <= 1'b0;
    end else if (fill_vld) begin
      buf_vld  <= 1'b1;
      buf_addr <= fill_addr;
      buf_dat  <= fill_dat;
    end
  end

  assign hit = buf_vld & (buf_addr == lookup_addr);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit between the controller and instruction memory.
// Latency: fetch_enable at N -> mem_req at N+1 -> fetch_valid at N+3 with zero-wait memory.
// Backpressure: mem_req/mem_addr held until mem_ready; instr_fetch held until new_instr.
//
// Ports: CLK, reset (async active-high); controller side fetch_enable,
// fetch_addr, new_instr, fetch_valid, instr_fetch; memory side mem_req,
// mem_addr, mem_ready, mem_rvalid, mem_rdata.
// Optional feature macro FETCH_PREFETCH_EN: while holding an instruction, fetch
// address+4 into a one-entry buffer and serve a matching fetch from it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = ADDR_W_DEF,
  parameter int                 INSTR_W     = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] RESET_INSTR = INSTR_W'(NOP_INSTR)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               fetch_enable,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               new_instr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] instr_fetch,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata
);

  fetch_state_t state;
  logic         discard;    // a response is owed by memory and must be dropped
  logic         accepted;
  logic         resp_open;  // memory owes a response for an earlier accepted request
  logic         drop_next;
  logic         start_req;
  logic         redirect;
  logic         restart;

  assign accepted  = mem_req & mem_ready;
  assign start_req = fetch_enable & ((state == ST_IDLE) | ((state == ST_VALID) & new_instr));
  assign redirect  = fetch_enable & ((state == ST_REQ) | (state == ST_WAIT)) &
                     (fetch_addr != mem_addr);
  // On a restart, a response still owed after this edge (including one for a
  // request accepted right now) must be drained before the new request goes
  // out, so only one request is ever outstanding. A redirect before acceptance
  // simply retargets the pending request.
  assign drop_next = accepted | (resp_open & ~mem_rvalid);

`ifdef FETCH_PREFETCH_EN
  logic               pf_req;     // mem_req currently carries a prefetch
  logic               pf_os;      // prefetch accepted, response owed
  logic               pf_vld;
  logic               pf_lookup_hit;
  logic               pf_hit;
  logic               pf_issue;
  logic               pf_fill_vld;
  logic [INSTR_W-1:0] pf_dat;

  assign resp_open   = (state == ST_WAIT) | discard | pf_os;
  assign pf_hit      = start_req & pf_lookup_hit;
  assign restart     = (start_req & ~pf_lookup_hit) | redirect;
  assign pf_issue    = (state == ST_VALID) & ~new_instr & ~mem_req & ~pf_os & ~pf_vld;
  assign pf_fill_vld = pf_os & mem_rvalid & ~restart;

  fetch_prefetch_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_pf_buf (
    .CLK         (CLK),
    .reset       (reset),
    .fill_vld    (pf_fill_vld),
    .fill_addr   (mem_addr),
    .fill_dat    (mem_rdata),
    .inval       (restart | pf_hit),
    .lookup_addr (fetch_addr),
    .buf_vld     (pf_vld),
    .buf_dat     (pf_dat),
    .hit         (pf_lookup_hit)
  );

  // Prefetch bookkeeping; a restart abandons it (the owed response, if any,
  // is accounted for by the discard flag).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pf_req <= 1'b0;
      pf_os  <= 1'b0;
    end else if (restart) begin
      pf_req <= 1'b0;
      pf_os  <= 1'b0;
    end else begin
      if (pf_issue) begin
        pf_req <= 1'b1;
      end else if (pf_req & mem_ready) begin
        pf_req <= 1'b0;
        pf_os  <= 1'b1;
      end
      if (pf_os & mem_rvalid) begin
        pf_os <= 1'b0;
      end
    end
  end
`else
  assign resp_open = (state == ST_WAIT) | discard;
  assign restart   = start_req | redirect;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_valid <= 1'b0;
      instr_fetch <= RESET_INSTR;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      discard     <= 1'b0;
    end else if (restart) begin
      // New fetch from IDLE/VALID, or a redirect from REQ/WAIT.
      state       <= ST_REQ;
      fetch_valid <= 1'b0;
      mem_addr    <= fetch_addr;
      discard     <= drop_next;
      mem_req     <= ~drop_next;
`ifdef FETCH_PREFETCH_EN
    end else if (pf_hit) begin
      state       <= ST_VALID;
      fetch_valid <= 1'b1;
      instr_fetch <= pf_dat;
      mem_addr    <= fetch_addr;
`endif
    end else begin
`ifdef FETCH_PREFETCH_EN
      if (pf_req & mem_ready) begin
        mem_req <= 1'b0;
      end
      if (pf_issue) begin
        mem_req  <= 1'b1;
        mem_addr <= mem_addr + ADDR_W'(4);
      end
`endif
      case (state)
        ST_IDLE: begin
        end
        ST_REQ: begin
          if (discard) begin
            // Stale response drained; now the request for mem_addr may go.
            if (mem_rvalid) begin
              discard <= 1'b0;
              mem_req <= 1'b1;
            end
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            instr_fetch <= mem_rdata;
            fetch_valid <= 1'b1;
            state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (new_instr) begin
            fetch_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: the bench acts as memory with random ready and response timing.
module tb_fetch_unit;

  logic        CLK;
  logic        reset;
  logic        fetch_enable;
  logic [19:0] fetch_addr;
  logic        new_instr;
  logic        fetch_valid;
  logic [31:0] instr_fetch;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  fetch_unit dut (
    .CLK          (CLK),
    .reset        (reset),
    .fetch_enable (fetch_enable),
    .fetch_addr   (fetch_addr),
    .new_instr    (new_instr),
    .fetch_valid  (fetch_valid),
    .instr_fetch  (instr_fetch),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: what the controller should currently see.
  // m_busy  - a fetch for m_tgt has been asked for and not yet delivered
  // m_owed  - memory has accepted a request and still owes its response
  // m_stale - the owed response belongs to an abandoned address
  logic        m_busy, m_valid, m_req, m_owed, m_stale;
  logic [19:0] m_tgt;
  logic [31:0] m_instr;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_req = 0; m_owed = 0; m_stale = 0;
    m_tgt = '0; m_instr = 32'h0000_0033;
  endtask

  // Advance the model by one cycle using the inputs held during that cycle.
  task automatic model_update();
    logic acc, start, redir, got, use_it;
    acc    = m_req && mem_ready;
    start  = !m_busy && fetch_enable && (!m_valid || new_instr);
    redir  = m_busy && fetch_enable && (fetch_addr != m_tgt);
    got    = m_owed && mem_rvalid;
    use_it = got && !m_stale && !redir;
    if (got) m_owed = 0;
    if (acc) begin m_owed = 1; m_stale = 0; end
    if (start || redir) begin
      m_stale = 1; m_busy = 1; m_tgt = fetch_addr; m_valid = 0;
    end
    if (use_it) begin
      m_valid = 1; m_instr = mem_rdata; m_busy = 0;
    end else if (!start && m_valid && new_instr) begin
      m_valid = 0;
    end
    m_req = m_busy && !m_owed;
  endtask

  task automatic step(input logic fe, input logic [19:0] fa, input logic ni,
                      input logic rdy, input logic rv, input logic [31:0] rd);
    fetch_enable = fe; fetch_addr = fa; new_instr = ni;
    mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
    if (mem_req && mem_ready) acc_cnt++;
    @(posedge CLK);
    if (reset) model_reset();
    else model_update();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
      chk("instr_fetch", instr_fetch, m_instr);
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
      if (m_busy) chk("mem_addr", {12'd0, mem_addr}, {12'd0, m_tgt});
    end
  end

  initial begin
    logic [19:0] a;
    reset = 1'b1;
    fetch_enable = 0; fetch_addr = '0; new_instr = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;

    // Reset values
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", instr_fetch, 32'h0000_0033);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
`ifndef FETCH_PREFETCH_EN
    chk_en = 1'b1;
`endif

    // Minimum latency fetch at 0x00000
    step(1, 20'h00000, 0, 0, 0, 0);
    chk("lat_req", {31'd0, mem_req}, 32'd1);
    chk("lat_addr", {12'd0, mem_addr}, 32'h0);
    step(0, 0, 0, 1, 0, 0);
    chk("lat_req_drop", {31'd0, mem_req}, 32'd0);
    chk("lat_not_yet", {31'd0, fetch_valid}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h0050_0093);
    chk("lat_valid", {31'd0, fetch_valid}, 32'd1);
    chk("lat_instr", instr_fetch, 32'h0050_0093);
    step(0, 0, 1, 0, 0, 0);
    chk("consume", {31'd0, fetch_valid}, 32'd0);

    // Stalled memory: request held stable for four cycles, one acceptance
    acc_cnt = 0;
    step(1, 20'h00010, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("stall_req", {31'd0, mem_req}, 32'd1);
      chk("stall_addr", {12'd0, mem_addr}, 32'h10);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("stall_accepted", {31'd0, mem_req}, 32'd0);

    // Redirect in WAIT to 0x00040: old response dropped
    step(1, 20'h00040, 0, 0, 0, 0);
    chk("one_accept", acc_cnt, 32'd1);
    chk("redir_no_req", {31'd0, mem_req}, 32'd0);
    step(0, 0, 0, 0, 1, 32'hAAAA_0010);
    chk("redir_dropped", {31'd0, fetch_valid}, 32'd0);
    chk("redir_req", {31'd0, mem_req}, 32'd1);
    chk("redir_addr", {12'd0, mem_addr}, 32'h40);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'hBBBB_0040);
    chk("redir_valid", {31'd0, fetch_valid}, 32'd1);
    chk("redir_instr", instr_fetch, 32'hBBBB_0040);

    // Consume and fetch 0x00014 in the same cycle
    step(1, 20'h00014, 1, 0, 0, 0);
    chk("b2b_valid_low", {31'd0, fetch_valid}, 32'd0);
    chk("b2b_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_addr", {12'd0, mem_addr}, 32'h14);

    // Reset while waiting; late response after release is ignored
    step(0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("rst_mid_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mid_instr", instr_fetch, 32'h0000_0033);
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);

`ifdef FETCH_PREFETCH_EN
    // Prefetch wraps past the top of the address space and serves a hit
    step(1, 20'hFFFFC, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1111_1111);
    step(0, 0, 0, 0, 0, 0);
    chk("pf_req", {31'd0, mem_req}, 32'd1);
    chk("pf_addr", {12'd0, mem_addr}, 32'h0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h2222_2222);
    step(1, 20'h00000, 1, 0, 0, 0);
    chk("pf_hit_valid", {31'd0, fetch_valid}, 32'd1);
    chk("pf_hit_instr", instr_fetch, 32'h2222_2222);
    chk("pf_hit_no_req", {31'd0, mem_req}, 32'd0);
`else
    // Randomized traffic: bench is the memory, the model predicts every cycle
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 4))
        0: a = 20'h00010;
        1: a = 20'h00040;
        2: a = 20'h00014;
        3: a = m_tgt;
        default: a = 20'($urandom) & 20'hFFFFC;
      endcase
      step($urandom_range(0, 99) < 30, a,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 50,
           m_owed ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10),
           $urandom);
    end
`endif

    @(negedge CLK);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
